pe_cfg_loader: RTL and testbench

Configuration initiator for a chain of `PE` blocks. It accepts weight words and per-PE control words from a host over valid/ready streams. It drives them onto the chain's `w_in`/`w_conf` shift path, then its `cntl_conf`/`d_ch_in`/`bp_ch_in`/`bp_src_in` shift path, and signals completion. It sits between the host/DMA side and the first PE of a chain of `NUM_PE` PEs.

---
 rtl/pe_cfg_pkg.sv | 27 ++
 rtl/pe_cfg_loader_if.sv | 24 ++
 rtl/pe_cfg_loader.sv | 135 +++++++++++++
 tb/tb_pe_cfg_loader.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_cfg_pkg.sv
// Shared types and constants for the PE-chain configuration loader.
// Control words are packed {bp_src, bp_ch, d_ch}, with d_ch in the LSBs.
package pe_cfg_pkg;

    localparam int KTAPS_DEFAULT = 9;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD_W = 2'd1,
        ST_LOAD_C = 2'd2,
        ST_FIN    = 2'd3
    } cfg_state_e;

    // Control word field positions, counted in CL_IN-wide slots from the LSB.
    localparam int D_CH_SLOT   = 0;
    localparam int BP_CH_SLOT  = 1;
    localparam int BP_SRC_SLOT = 2;

    function automatic int ctrl_off(input int slot, input int cl_in);
        return slot * cl_in;
    endfunction

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pe_cfg_loader_if.sv
// Host-side weight and control streams feeding the configuration loader.
// Both streams use a valid/ready handshake.
interface pe_cfg_loader_if #(
    parameter int CL_IN = 4,
    parameter int M     = 4,
    parameter int CL1   = 2
);
    logic [CL_IN*M-1:0]     s_w_data;
    logic                   s_w_valid;
    logic                   s_w_ready;
    logic [2*CL_IN+CL1-1:0] s_c_data;
    logic                   s_c_valid;
    logic                   s_c_ready;

    modport master (
        output s_w_data, s_w_valid, s_c_data, s_c_valid,
        input  s_w_ready, s_c_ready
    );

    modport slave (
        input  s_w_data, s_w_valid, s_c_data, s_c_valid,
        output s_w_ready, s_c_ready
    );
endinterface

// File: rtl/pe_cfg_loader.sv
// Streams KTAPS*NUM_PE weight words and then NUM_PE control words into a PE chain.
// The first word supplied shifts farthest down the chain.
module pe_cfg_loader
    import pe_cfg_pkg::*;
#(
    parameter int CL_IN  = 4,
    parameter int CL1    = 2,
    parameter int M      = 4,
    parameter int NUM_PE = 4,
    parameter int KTAPS  = KTAPS_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    pe_cfg_loader_if.slave     host,
    output logic [CL_IN*M-1:0] w_in,
    output logic               w_conf,
    output logic               cntl_conf,
    output logic [CL_IN-1:0]   d_ch_in,
    output logic [CL_IN-1:0]   bp_ch_in,
    output logic [CL1-1:0]     bp_src_in,
    output logic               busy,
    output logic               done
);

    localparam int W_BEATS  = KTAPS * NUM_PE;
    localparam int WCNT_W   = cnt_width(W_BEATS);
    localparam int CCNT_W   = cnt_width(NUM_PE);
    localparam int D_OFF    = ctrl_off(D_CH_SLOT, CL_IN);
    localparam int BPCH_OFF = ctrl_off(BP_CH_SLOT, CL_IN);
    localparam int BPSR_OFF = ctrl_off(BP_SRC_SLOT, CL_IN);

    localparam logic [WCNT_W-1:0] W_LAST = WCNT_W'(W_BEATS - 1);
    localparam logic [CCNT_W-1:0] C_LAST = CCNT_W'(NUM_PE - 1);

    cfg_state_e          state_q, state_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [CCNT_W-1:0]   ccnt_q, ccnt_d;
    logic [CL_IN*M-1:0]  w_in_q, w_in_d;
    logic                w_conf_q, w_conf_d;
    logic                cntl_conf_q, cntl_conf_d;
    logic [CL_IN-1:0]    d_ch_q, d_ch_d;
    logic [CL_IN-1:0]    bp_ch_q, bp_ch_d;
    logic [CL1-1:0]      bp_src_q, bp_src_d;
    logic                done_q, done_d;
    logic                w_acc, c_acc;

    // Readies depend on state only so the host never sees a valid->ready loop.
    assign host.s_w_ready = (state_q == ST_LOAD_W);
    assign host.s_c_ready = (state_q == ST_LOAD_C);
    assign w_acc = host.s_w_ready && host.s_w_valid;
    assign c_acc = host.s_c_ready && host.s_c_valid;

    always_comb begin
        state_d     = state_q;
        wcnt_d      = wcnt_q;
        ccnt_d      = ccnt_q;
        w_in_d      = w_in_q;
        d_ch_d      = d_ch_q;
        bp_ch_d     = bp_ch_q;
        bp_src_d    = bp_src_q;
        w_conf_d    = 1'b0;
        cntl_conf_d = 1'b0;
        done_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_LOAD_W;
                    wcnt_d  = '0;
                    ccnt_d  = '0;
                end
            end
            ST_LOAD_W: begin
                if (w_acc) begin
                    w_in_d   = host.s_w_data;
                    w_conf_d = 1'b1;
                    if (wcnt_q == W_LAST) state_d = ST_LOAD_C;
                    else                  wcnt_d  = wcnt_q + 1'b1;
                end
            end
            ST_LOAD_C: begin
                if (c_acc) begin
                    d_ch_d      = host.s_c_data[D_OFF +: CL_IN];
                    bp_ch_d     = host.s_c_data[BPCH_OFF +: CL_IN];
                    bp_src_d    = host.s_c_data[BPSR_OFF +: CL1];
                    cntl_conf_d = 1'b1;
                    if (ccnt_q == C_LAST) state_d = ST_FIN;
                    else                  ccnt_d  = ccnt_q + 1'b1;
                end
            end
            ST_FIN: begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            wcnt_q      <= '0;
            ccnt_q      <= '0;
            w_in_q      <= '0;
            w_conf_q    <= 1'b0;
            cntl_conf_q <= 1'b0;
            d_ch_q      <= '0;
            bp_ch_q     <= '0;
            bp_src_q    <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wcnt_q      <= wcnt_d;
            ccnt_q      <= ccnt_d;
            w_in_q      <= w_in_d;
            w_conf_q    <= w_conf_d;
            cntl_conf_q <= cntl_conf_d;
            d_ch_q      <= d_ch_d;
            bp_ch_q     <= bp_ch_d;
            bp_src_q    <= bp_src_d;
            done_q      <= done_d;
        end
    end

    assign w_in      = w_in_q;
    assign w_conf    = w_conf_q;
    assign cntl_conf = cntl_conf_q;
    assign d_ch_in   = d_ch_q;
    assign bp_ch_in  = bp_ch_q;
    assign bp_src_in = bp_src_q;
    assign done      = done_q;
    assign busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pe_cfg_loader.sv
// Scoreboard bench for pe_cfg_loader: a 4-PE and a 1-PE instance share the stimulus.
// Accepted beats are queued and popped when the matching shift enable appears.
module tb_pe_cfg_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start_v, sel1, w_valid, c_valid;
    logic [15:0] w_data;
    logic [9:0]  c_data;
    logic        start4, start1;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] qw[$];
    logic [9:0]  qc[$];

    pe_cfg_loader_if #(.CL_IN(4), .M(4), .CL1(2)) bus4 ();
    pe_cfg_loader_if #(.CL_IN(4), .M(4), .CL1(2)) bus1 ();

    assign start4 = start_v && !sel1;
    assign start1 = start_v && sel1;
    assign bus4.s_w_data  = w_data;
    assign bus4.s_w_valid = w_valid;
    assign bus4.s_c_data  = c_data;
    assign bus4.s_c_valid = c_valid;
    assign bus1.s_w_data  = w_data;
    assign bus1.s_w_valid = w_valid;
    assign bus1.s_c_data  = c_data;
    assign bus1.s_c_valid = c_valid;

    logic [15:0] w_in4, w_in1;
    logic        w_conf4, w_conf1, cntl_conf4, cntl_conf1;
    logic [3:0]  d_ch4, d_ch1, bp_ch4, bp_ch1;
    logic [1:0]  bp_src4, bp_src1;
    logic        busy4, busy1, done4, done1;

    pe_cfg_loader #(.CL_IN(4), .CL1(2), .M(4), .NUM_PE(4), .KTAPS(9)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .host(bus4),
        .w_in(w_in4), .w_conf(w_conf4), .cntl_conf(cntl_conf4),
        .d_ch_in(d_ch4), .bp_ch_in(bp_ch4), .bp_src_in(bp_src4),
        .busy(busy4), .done(done4)
    );

    pe_cfg_loader #(.CL_IN(4), .CL1(2), .M(4), .NUM_PE(1), .KTAPS(9)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .host(bus1),
        .w_in(w_in1), .w_conf(w_conf1), .cntl_conf(cntl_conf1),
        .d_ch_in(d_ch1), .bp_ch_in(bp_ch1), .bp_src_in(bp_src1),
        .busy(busy1), .done(done1)
    );

    // Runs whole passes edge by edge against a small phase model of the loader.
    // Edge e is the rising edge after which the sampled outputs are cycle e+1.
    task automatic run_pass(input bit use1, input int stall_mod, input bit poke,
                            input int rst_after, input int passes,
                            output int done_edge, output int ndone, output int nw,
                            output int nc, output int gaps);
        int npe, wb, ph, wk, ck, next_start;
        bit acc_w, acc_c, exp_done, did_rst;
        bit o_wr, o_cr, o_wc, o_cc, o_done, o_busy;
        logic [15:0] o_win, ew;
        logic [9:0]  o_cw, ec;
        npe = use1 ? 1 : 4;
        wb = 9 * npe;
        ph = 0; wk = 0; ck = 0; next_start = 0; did_rst = 1'b0;
        sel1 = use1;
        done_edge = -1; ndone = 0; nw = 0; nc = 0; gaps = 0;
        qw.delete(); qc.delete();
        for (int e = 0; e < 400 && ndone < passes; e++) begin
            start_v = (passes > 1) || (e == next_start) || (poke && (e == 10 || e == 38));
            w_valid = !(stall_mod > 0 && (e % stall_mod) == stall_mod - 1);
            c_valid = 1'b1;
            rst     = (rst_after >= 0) && !did_rst && (ph == 1) && (wk == rst_after);
            w_data  = 16'(wk);
            c_data  = use1 ? 10'h3A5 : 10'(ck * 173 + 85);
            #1;
            o_wr = use1 ? bus1.s_w_ready : bus4.s_w_ready;
            o_cr = use1 ? bus1.s_c_ready : bus4.s_c_ready;
            n_cmp++;
            if (o_wr !== (ph == 1)) begin
                n_err++;
                $display("FAIL w_ready edge %0d: got %0b expected %0b", e, o_wr, ph == 1);
            end
            n_cmp++;
            if (o_cr !== (ph == 2)) begin
                n_err++;
                $display("FAIL c_ready edge %0d: got %0b expected %0b", e, o_cr, ph == 2);
            end
            acc_w    = !rst && ph == 1 && w_valid;
            acc_c    = !rst && ph == 2 && c_valid;
            exp_done = !rst && ph == 3;
            if (!rst && ph == 1 && !w_valid) gaps++;
            if (rst) begin
                ph = 0; wk = 0; ck = 0; did_rst = 1'b1; next_start = e + 1;
                qw.delete(); qc.delete();
            end else begin
                case (ph)
                    0: if (start_v) begin ph = 1; wk = 0; ck = 0; end
                    1: if (acc_w) begin
                        qw.push_back(w_data); wk++;
                        if (wk == wb) ph = 2;
                    end
                    2: if (acc_c) begin
                        qc.push_back(c_data); ck++;
                        if (ck == npe) ph = 3;
                    end
                    default: ph = 0;
                endcase
            end
            @(posedge clk);
            #1;
            rst    = 1'b0;
            o_wc   = use1 ? w_conf1 : w_conf4;
            o_cc   = use1 ? cntl_conf1 : cntl_conf4;
            o_done = use1 ? done1 : done4;
            o_busy = use1 ? busy1 : busy4;
            o_win  = use1 ? w_in1 : w_in4;
            o_cw   = use1 ? {bp_src1, bp_ch1, d_ch1} : {bp_src4, bp_ch4, d_ch4};
            n_cmp++;
            if (o_wc !== acc_w) begin
                n_err++;
                $display("FAIL w_conf cycle %0d: got %0b expected %0b", e + 1, o_wc, acc_w);
            end
            n_cmp++;
            if (o_cc !== acc_c) begin
                n_err++;
                $display("FAIL cntl_conf cycle %0d: got %0b expected %0b", e + 1, o_cc, acc_c);
            end
            n_cmp++;
            if (o_done !== exp_done) begin
                n_err++;
                $display("FAIL done cycle %0d: got %0b expected %0b", e + 1, o_done, exp_done);
            end
            n_cmp++;
            if (o_busy !== (ph != 0)) begin
                n_err++;
                $display("FAIL busy cycle %0d: got %0b expected %0b", e + 1, o_busy, ph != 0);
            end
            if (o_wc === 1'b1) begin
                nw++;
                n_cmp++;
                if (qw.size() == 0) begin
                    n_err++;
                    $display("FAIL w_in cycle %0d: got %0h expected no beat", e + 1, o_win);
                end else begin
                    ew = qw.pop_front();
                    if (o_win !== ew) begin
                        n_err++;
                        $display("FAIL w_in cycle %0d: got %0h expected %0h", e + 1, o_win, ew);
                    end
                end
            end
            if (o_cc === 1'b1) begin
                nc++;
                n_cmp++;
                if (qc.size() == 0) begin
                    n_err++;
                    $display("FAIL ctrl cycle %0d: got %0h expected no beat", e + 1, o_cw);
                end else begin
                    ec = qc.pop_front();
                    if (o_cw !== ec) begin
                        n_err++;
                        $display("FAIL ctrl cycle %0d: got %0h expected %0h", e + 1, o_cw, ec);
                    end
                end
            end
            if (o_done === 1'b1) begin
                ndone++;
                done_edge = e;
            end
        end
        n_cmp++;
        if (ndone < passes || qw.size() != 0 || qc.size() != 0) begin
            n_err++;
            $display("FAIL pass_end: got %0d done, %0d/%0d left; expected %0d done, 0/0 left",
                     ndone, qw.size(), qc.size(), passes);
        end
        start_v = 1'b0;
        $display("pass npe=%0d stall=%0d: %0d w_conf, %0d cntl_conf, done at edge %0d",
                 npe, stall_mod, nw, nc, done_edge);
    endtask

    task automatic test_reset();
        rst = 1'b1; start_v = 1'b1; sel1 = 1'b0; w_valid = 1'b1; c_valid = 1'b1;
        w_data = 16'hFFFF; c_data = 10'h3FF;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++; if (bus4.s_w_ready !== 1'b0) begin n_err++; $display("FAIL rst_w_ready: got %0b expected 0", bus4.s_w_ready); end
        n_cmp++; if (bus4.s_c_ready !== 1'b0) begin n_err++; $display("FAIL rst_c_ready: got %0b expected 0", bus4.s_c_ready); end
        n_cmp++; if (w_conf4 !== 1'b0) begin n_err++; $display("FAIL rst_w_conf: got %0b expected 0", w_conf4); end
        n_cmp++; if (cntl_conf4 !== 1'b0) begin n_err++; $display("FAIL rst_cntl_conf: got %0b expected 0", cntl_conf4); end
        n_cmp++; if (done4 !== 1'b0) begin n_err++; $display("FAIL rst_done: got %0b expected 0", done4); end
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %0b expected 0", busy4); end
        n_cmp++; if (w_in4 !== 16'h0) begin n_err++; $display("FAIL rst_w_in: got %0h expected 0", w_in4); end
        n_cmp++; if ({bp_src4, bp_ch4, d_ch4} !== 10'h0) begin n_err++; $display("FAIL rst_ctrl: got %0h expected 0", {bp_src4, bp_ch4, d_ch4}); end
        n_cmp++; if (busy1 !== 1'b0) begin n_err++; $display("FAIL rst_busy1: got %0b expected 0", busy1); end
        rst = 1'b0; start_v = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++; if (busy4 !== 1'b0) begin n_err++; $display("FAIL idle_after_rst: got %0b expected 0", busy4); end
        $display("reset checks done");
    endtask

    task automatic test_basic();
        int de, nd, nw, nc, g;
        run_pass(1'b0, 0, 1'b0, -1, 1, de, nd, nw, nc, g);
        n_cmp++; if (de != 41) begin n_err++; $display("FAIL basic_done_edge: got %0d expected 41", de); end
        n_cmp++; if (nw != 36 || nc != 4) begin n_err++; $display("FAIL basic_counts: got %0d/%0d expected 36/4", nw, nc); end
    endtask

    task automatic test_stalls();
        int de, nd, nw, nc, g;
        run_pass(1'b0, 3, 1'b0, -1, 1, de, nd, nw, nc, g);
        n_cmp++; if (g != 18) begin n_err++; $display("FAIL stall_gaps: got %0d expected 18", g); end
        n_cmp++; if (de != 59) begin n_err++; $display("FAIL stall_done_edge: got %0d expected 59", de); end
        n_cmp++; if (nw != 36) begin n_err++; $display("FAIL stall_w_count: got %0d expected 36", nw); end
    endtask

    task automatic test_start_while_busy();
        int de, nd, nw, nc, g;
        run_pass(1'b0, 0, 1'b1, -1, 1, de, nd, nw, nc, g);
        n_cmp++; if (de != 41 || nw != 36 || nc != 4) begin n_err++; $display("FAIL busy_start: got edge %0d %0d/%0d expected 41 36/4", de, nw, nc); end
        repeat (4) begin
            @(posedge clk);
            #1;
            n_cmp++;
            if (done4 !== 1'b0 || busy4 !== 1'b0) begin
                n_err++;
                $display("FAIL busy_start_idle: got done %0b busy %0b expected 0 0", done4, busy4);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        int de, nd, nw, nc, g;
        run_pass(1'b0, 0, 1'b0, 10, 1, de, nd, nw, nc, g);
        n_cmp++; if (de != 53) begin n_err++; $display("FAIL rst_mid_done_edge: got %0d expected 53", de); end
        n_cmp++; if (nw != 46 || nc != 4) begin n_err++; $display("FAIL rst_mid_counts: got %0d/%0d expected 46/4", nw, nc); end
    endtask

    task automatic test_num_pe1();
        int de, nd, nw, nc, g;
        run_pass(1'b1, 0, 1'b0, -1, 1, de, nd, nw, nc, g);
        n_cmp++; if (de != 11) begin n_err++; $display("FAIL pe1_done_edge: got %0d expected 11", de); end
        n_cmp++; if (nw != 9 || nc != 1) begin n_err++; $display("FAIL pe1_counts: got %0d/%0d expected 9/1", nw, nc); end
        n_cmp++; if (bp_src1 !== 2'd3) begin n_err++; $display("FAIL pe1_bp_src: got %0d expected 3", bp_src1); end
        n_cmp++; if (bp_ch1 !== 4'b1010) begin n_err++; $display("FAIL pe1_bp_ch: got %b expected 1010", bp_ch1); end
        n_cmp++; if (d_ch1 !== 4'b0101) begin n_err++; $display("FAIL pe1_d_ch: got %b expected 0101", d_ch1); end
        sel1 = 1'b0;
    endtask

    task automatic test_back_to_back();
        int de, nd, nw, nc, g;
        run_pass(1'b0, 0, 1'b0, -1, 2, de, nd, nw, nc, g);
        n_cmp++; if (nd != 2 || de != 83) begin n_err++; $display("FAIL b2b_done: got %0d at edge %0d expected 2 at 83", nd, de); end
        n_cmp++; if (nw != 72 || nc != 8) begin n_err++; $display("FAIL b2b_counts: got %0d/%0d expected 72/8", nw, nc); end
    endtask

    initial begin
        rst = 1'b1; start_v = 1'b0; sel1 = 1'b0; w_valid = 1'b0; c_valid = 1'b0;
        w_data = '0; c_data = '0;
        test_reset();
        test_basic();
        test_stalls();
        test_start_while_busy();
        test_reset_mid_pass();
        test_num_pe1();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
